// File: rtl/sync_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_pattern_tx_if
//  Description : Request/stream bundle for the framed serial transmitter.
//                master drives start/data_in and observes the stream;
//                slave (the transmitter) drives o/busy/done.
//  Signals     : start   - request to send a frame
//                data_in - payload word, DATA_BITS wide
//                o       - serial bit stream
//                busy    - frame in progress
//                done    - one-cycle end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_pattern_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] data_in;
  logic                 o;
  logic                 busy;
  logic                 done;

  modport master (output start, output data_in, input o, input busy, input done);
  modport slave  (input start, input data_in, output o, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/sync_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sync_pattern_tx
//  Description : Framed serial transmitter. Each frame is a SYNC_LEN-bit
//                preamble (MSB first), a DATA_BITS payload (MSB first) and
//                GAP_BITS zero guard bits; every bit is held CLKS_PER_BIT
//                clocks. All outputs are registered.
//  Ports       : clk       - system clock, rising edge
//                rst       - synchronous active-high reset
//                bus.start - frame request, sampled only when idle
//                bus.data_in - payload, latched when start is accepted
//                bus.o     - serial stream
//                bus.busy  - high while SYNC/DATA/GAP
//                bus.done  - one-cycle pulse at frame completion
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_pattern_tx #(
  parameter int                  DATA_BITS    = 8,
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT     = 4'b1101,
  parameter int                  GAP_BITS     = 2,
  parameter int                  CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  sync_pattern_tx_if.slave   bus
);

  localparam int C_MAX_SD  = (SYNC_LEN > DATA_BITS) ? SYNC_LEN : DATA_BITS;
  localparam int C_MAX_LEN = (C_MAX_SD > GAP_BITS) ? C_MAX_SD : GAP_BITS;
  localparam int BCW       = $clog2(C_MAX_LEN + 1);
  localparam int HCW       = $clog2(CLKS_PER_BIT + 1);

  localparam logic [HCW-1:0] C_HOLD_MAX  = HCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] C_SYNC_LAST = BCW'(SYNC_LEN - 1);
  localparam logic [BCW-1:0] C_DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] C_GAP_LAST  = BCW'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [HCW-1:0]       hold_q, hold_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [SYNC_LEN-1:0]  sync_q, sync_d;
  logic                 o_q, o_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap;

  // A bit-time ends when the hold counter reaches its last count.
  assign wrap = (hold_q == C_HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sync_q  <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sync_d  = sync_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_d    = 1'b0;
        busy_d = 1'b0;
        hold_d = '0;
        bit_d  = '0;
        if (bus.start) begin
          // First preamble bit goes out on the accepting edge; the remaining
          // preamble bits are queued pre-shifted so the MSB is always next.
          state_d = S_SYNC;
          shreg_d = bus.data_in;
          sync_d  = SYNC_PAT << 1;
          o_d     = SYNC_PAT[SYNC_LEN-1];
          busy_d  = 1'b1;
        end
      end

      S_SYNC: begin
        hold_d = wrap ? '0 : hold_q + 1'b1;
        if (wrap) begin
          if (bit_q == C_SYNC_LAST) begin
            state_d = S_DATA;
            bit_d   = '0;
            o_d     = shreg_q[DATA_BITS-1];
            shreg_d = shreg_q << 1;
          end else begin
            bit_d  = bit_q + 1'b1;
            o_d    = sync_q[SYNC_LEN-1];
            sync_d = sync_q << 1;
          end
        end
      end

      S_DATA: begin
        hold_d = wrap ? '0 : hold_q + 1'b1;
        if (wrap) begin
          if (bit_q == C_DATA_LAST) begin
            state_d = S_GAP;
            bit_d   = '0;
            o_d     = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            o_d     = shreg_q[DATA_BITS-1];
            shreg_d = shreg_q << 1;
          end
        end
      end

      S_GAP: begin
        hold_d = wrap ? '0 : hold_q + 1'b1;
        o_d    = 1'b0;
        if (wrap) begin
          if (bit_q == C_GAP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
        bit_d   = '0;
        o_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign bus.o    = o_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_pattern_tx
//  Description : Directed self-checking bench for sync_pattern_tx. Uses a
//                default instance and a CLKS_PER_BIT=3 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_pattern_tx;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sync_pattern_tx_if #(.DATA_BITS(8)) if1 ();
  sync_pattern_tx_if #(.DATA_BITS(8)) if3 ();

  sync_pattern_tx #(
    .DATA_BITS(8), .SYNC_LEN(4), .SYNC_PAT(4'b1101), .GAP_BITS(2), .CLKS_PER_BIT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  sync_pattern_tx #(
    .DATA_BITS(8), .SYNC_LEN(4), .SYNC_PAT(4'b1101), .GAP_BITS(2), .CLKS_PER_BIT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs
  // changed 1 ns later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.start = 1'b1;
    if1.data_in = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (if1.o !== 1'b0) begin n_fail++; $display("FAIL reset_o cyc%0d: got %b want 0", i, if1.o); end
      n_checks++;
      if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, if1.busy); end
      n_checks++;
      if (if1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done cyc%0d: got %b want 0", i, if1.done); end
    end
    if1.start = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_frame: busy got %b want 0", if1.busy); end
  endtask

  // Single A5 frame, with an ignored FF start request at cycle 5.
  task automatic test_single_frame();
    logic [13:0] exp;
    exp = 14'b1101_1010_0101_00;
    if1.data_in = 8'hA5;
    if1.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) begin if1.start = 1'b0; if1.data_in = 8'h00; end
      n_checks++;
      if (if1.o !== exp[13-i]) begin n_fail++; $display("FAIL single_o bit%0d: got %b want %b", i, if1.o, exp[13-i]); end
      n_checks++;
      if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy bit%0d: got %b want 1", i, if1.busy); end
      n_checks++;
      if (if1.done !== 1'b0) begin n_fail++; $display("FAIL single_done_early bit%0d: got %b want 0", i, if1.done); end
      if (i == 3) begin if1.start = 1'b1; if1.data_in = 8'hFF; end
      if (i == 4) begin if1.start = 1'b0; if1.data_in = 8'h00; end
    end
    tick();
    n_checks++;
    if (if1.done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", if1.done); end
    n_checks++;
    if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", if1.busy); end
    n_checks++;
    if (if1.o !== 1'b0) begin n_fail++; $display("FAIL single_o_end: got %b want 0", if1.o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_after cyc%0d: done=%b busy=%b want 0/0", i, if1.done, if1.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp;
    exp = 15'b1101_0000_0000_00_0;
    if1.data_in = 8'h00;
    if1.start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 15; k++) begin
        tick();
        n_checks++;
        if (if1.o !== exp[14-k]) begin n_fail++; $display("FAIL b2b_o f%0d k%0d: got %b want %b", p, k, if1.o, exp[14-k]); end
        n_checks++;
        if (if1.busy !== (k < 14)) begin n_fail++; $display("FAIL b2b_busy f%0d k%0d: got %b want %b", p, k, if1.busy, (k < 14)); end
        n_checks++;
        if (if1.done !== (k == 14)) begin n_fail++; $display("FAIL b2b_done f%0d k%0d: got %b want %b", p, k, if1.done, (k == 14)); end
      end
    end
    if1.start = 1'b0;
    tick();
    n_checks++;
    if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: busy got %b want 0", if1.busy); end
  endtask

  task automatic test_clks_per_bit3();
    logic [13:0] exp;
    int          n_done;
    exp = 14'b1101_1000_0000_00;
    n_done = 0;
    if3.data_in = 8'h80;
    if3.start = 1'b1;
    for (int j = 0; j < 42; j++) begin
      tick();
      if (j == 0) if3.start = 1'b0;
      n_checks++;
      if (if3.o !== exp[13-(j/3)]) begin n_fail++; $display("FAIL cpb3_o cyc%0d: got %b want %b", j, if3.o, exp[13-(j/3)]); end
      n_checks++;
      if (if3.busy !== 1'b1) begin n_fail++; $display("FAIL cpb3_busy cyc%0d: got %b want 1", j, if3.busy); end
      if (if3.done === 1'b1) n_done++;
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      if (if3.done === 1'b1) n_done++;
      if (j == 0) begin
        n_checks++;
        if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL cpb3_busy_end: got %b want 0", if3.busy); end
        n_checks++;
        if (if3.done !== 1'b1) begin n_fail++; $display("FAIL cpb3_done: got %b want 1", if3.done); end
      end
    end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL cpb3_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_mid_reset();
    logic [13:0] exp;
    exp = 14'b1101_1111_1111_00;
    if1.data_in = 8'hFF;
    if1.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) if1.start = 1'b0;
    end
    // Last sample was DATA bit 3; reset at the next edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (if1.o !== 1'b0) begin n_fail++; $display("FAIL midrst_o: got %b want 0", if1.o); end
    n_checks++;
    if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", if1.busy); end
    n_checks++;
    if (if1.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", if1.done); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (if1.done !== 1'b0 || if1.busy !== 1'b0 || if1.o !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_idle cyc%0d: o=%b busy=%b done=%b want 0/0/0", i, if1.o, if1.busy, if1.done);
      end
    end
    if1.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) if1.start = 1'b0;
      n_checks++;
      if (if1.o !== exp[13-i]) begin n_fail++; $display("FAIL midrst_frame_o bit%0d: got %b want %b", i, if1.o, exp[13-i]); end
    end
    tick();
    n_checks++;
    if (if1.done !== 1'b1) begin n_fail++; $display("FAIL midrst_frame_done: got %b want 1", if1.done); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    if1.start = 1'b0;
    if1.data_in = 8'h00;
    if3.start = 1'b0;
    if3.data_in = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_clks_per_bit3();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
